// File: rtl/mips_pipeline_core.sv
// Five-stage MIPS-subset pipeline (F/D/E/M/W). Control flow resolves in D with one
// always-executed delay slot. E/M/W results forward to D and E, and interlocks cover load-use and branch-operand hazards.
module mips_pipeline_core #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] i_inst_addr,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] m_data_addr,
  input  logic [31:0] m_data_rdata,
  output logic [31:0] m_data_wdata,
  output logic [3:0]  m_data_byteen,
  output logic [31:0] m_inst_addr,
  output logic        w_grf_we,
  output logic [4:0]  w_grf_addr,
  output logic [31:0] w_grf_wdata,
  output logic [31:0] w_inst_addr
);
  localparam logic [5:0] OP_R   = 6'h00;
  localparam logic [5:0] OP_JAL = 6'h03;
  localparam logic [5:0] OP_BEQ = 6'h04;
  localparam logic [5:0] OP_ORI = 6'h0d;
  localparam logic [5:0] OP_LUI = 6'h0f;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2b;

  typedef enum logic [2:0] {
    ALU_NONE, ALU_ADDU, ALU_SUBU, ALU_ORI, ALU_LUI, ALU_MEM, ALU_LINK
  } alu_e;

  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_instr_q, fd_instr_d, fd_pc_q, fd_pc_d;

  alu_e        de_alu_q, de_alu_d;
  logic        de_wr_q, de_wr_d, de_lw_q, de_lw_d;
  logic        de_sw_q, de_sw_d, de_sh_q, de_sh_d, de_sb_q, de_sb_d;
  logic [4:0]  de_dst_q, de_dst_d, de_rsa_q, de_rsa_d, de_rta_q, de_rta_d;
  logic [15:0] de_imm_q, de_imm_d;
  logic [31:0] de_pc_q, de_pc_d, de_rsv_q, de_rsv_d, de_rtv_q, de_rtv_d;

  logic        em_wr_q, em_wr_d, em_lw_q, em_lw_d;
  logic        em_sw_q, em_sw_d, em_sh_q, em_sh_d, em_sb_q, em_sb_d;
  logic [4:0]  em_dst_q, em_dst_d;
  logic [31:0] em_pc_q, em_pc_d, em_res_q, em_res_d, em_st_q, em_st_d;

  logic        mw_wr_q, mw_wr_d;
  logic [4:0]  mw_dst_q, mw_dst_d;
  logic [31:0] mw_pc_q, mw_pc_d, mw_data_q, mw_data_d;

  logic [31:0] grf_q [32];

  // D-stage decode
  logic [5:0]  d_op, d_funct;
  logic [4:0]  d_rs, d_rt, d_rd, d_shamt;
  logic [15:0] d_imm;
  logic        d_rtype, d_addu, d_subu, d_jr, d_ori, d_lui, d_lw, d_sw, d_sh, d_sb, d_beq, d_jal;
  logic        d_use_rs, d_use_rt, stall;
  logic [31:0] d_rs_val, d_rt_val, d_pc4, d_sext;

  assign d_op    = fd_instr_q[31:26];
  assign d_rs    = fd_instr_q[25:21];
  assign d_rt    = fd_instr_q[20:16];
  assign d_rd    = fd_instr_q[15:11];
  assign d_shamt = fd_instr_q[10:6];
  assign d_funct = fd_instr_q[5:0];
  assign d_imm   = fd_instr_q[15:0];

  assign d_rtype  = (d_op == OP_R) && (d_shamt == 5'd0);
  assign d_addu   = d_rtype && (d_funct == 6'h21 || d_funct == 6'h20);
  assign d_subu   = d_rtype && (d_funct == 6'h23 || d_funct == 6'h22);
  assign d_jr     = d_rtype && (d_funct == 6'h08);
  assign d_ori    = (d_op == OP_ORI);
  assign d_lui    = (d_op == OP_LUI);
  assign d_lw     = (d_op == OP_LW);
  assign d_sw     = (d_op == OP_SW);
  assign d_sh     = (d_op == OP_SH);
  assign d_sb     = (d_op == OP_SB);
  assign d_beq    = (d_op == OP_BEQ);
  assign d_jal    = (d_op == OP_JAL);
  assign d_use_rs = d_addu | d_subu | d_jr | d_ori | d_lw | d_sw | d_sh | d_sb | d_beq;
  assign d_use_rt = d_addu | d_subu | d_sw | d_sh | d_sb | d_beq;

  // Only a jal in E has its value ready early (PC+8); other E results are stalled on.
  function automatic logic [31:0] read_d(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (de_alu_q == ALU_LINK && de_dst_q == a) return de_pc_q + 32'd8;
    if (em_wr_q && !em_lw_q && em_dst_q == a) return em_res_q;
    if (mw_wr_q && mw_dst_q == a) return mw_data_q;
    return grf_q[a];
  endfunction

  function automatic logic br_hit(input logic [4:0] a);
    return (a != 5'd0) && (((d_beq | d_jr) && d_rs == a) || (d_beq && d_rt == a));
  endfunction

  function automatic logic [31:0] read_e(input logic [4:0] a, input logic [31:0] v);
    if (a == 5'd0) return 32'd0;
    if (em_wr_q && !em_lw_q && em_dst_q == a) return em_res_q;
    if (mw_wr_q && mw_dst_q == a) return mw_data_q;
    return v;
  endfunction

  always_comb begin
    d_rs_val = read_d(d_rs);
    d_rt_val = read_d(d_rt);
    d_pc4    = fd_pc_q + 32'd4;
    d_sext   = {{16{d_imm[15]}}, d_imm};

    stall = (de_lw_q && de_dst_q != 5'd0 &&
             ((d_use_rs && d_rs == de_dst_q) || (d_use_rt && d_rt == de_dst_q)))
         || (de_wr_q && !de_lw_q && de_alu_q != ALU_LINK && br_hit(de_dst_q))
         || (em_lw_q && br_hit(em_dst_q));

    pc_d = pc_q + 32'd4;
    if (stall)                                pc_d = pc_q;
    else if (d_jal)                           pc_d = {d_pc4[31:28], fd_instr_q[25:0], 2'b00};
    else if (d_jr)                            pc_d = d_rs_val;
    else if (d_beq && d_rs_val == d_rt_val)   pc_d = d_pc4 + (d_sext << 2);

    fd_instr_d = stall ? fd_instr_q : i_inst_rdata;
    fd_pc_d    = stall ? fd_pc_q : pc_q;

    // A stall sends a bubble into E (all-zero register set).
    de_alu_d = ALU_NONE;
    de_wr_d  = 1'b0;
    de_lw_d  = 1'b0;
    de_sw_d  = 1'b0;
    de_sh_d  = 1'b0;
    de_sb_d  = 1'b0;
    de_dst_d = 5'd0;
    de_rsa_d = 5'd0;
    de_rta_d = 5'd0;
    de_imm_d = 16'd0;
    de_pc_d  = 32'd0;
    de_rsv_d = 32'd0;
    de_rtv_d = 32'd0;
    if (!stall) begin
      if (d_addu)                          de_alu_d = ALU_ADDU;
      else if (d_subu)                     de_alu_d = ALU_SUBU;
      else if (d_ori)                      de_alu_d = ALU_ORI;
      else if (d_lui)                      de_alu_d = ALU_LUI;
      else if (d_lw | d_sw | d_sh | d_sb)  de_alu_d = ALU_MEM;
      else if (d_jal)                      de_alu_d = ALU_LINK;
      de_wr_d = d_addu | d_subu | d_ori | d_lui | d_lw | d_jal;
      de_lw_d = d_lw;
      de_sw_d = d_sw;
      de_sh_d = d_sh;
      de_sb_d = d_sb;
      if (d_addu | d_subu)             de_dst_d = d_rd;
      else if (d_ori | d_lui | d_lw)   de_dst_d = d_rt;
      else if (d_jal)                  de_dst_d = 5'd31;
      de_rsa_d = d_rs;
      de_rta_d = d_rt;
      de_imm_d = d_imm;
      de_pc_d  = fd_pc_q;
      de_rsv_d = d_rs_val;
      de_rtv_d = d_rt_val;
    end
  end

  // E stage
  logic [31:0] e_a, e_b;

  always_comb begin
    e_a = read_e(de_rsa_q, de_rsv_q);
    e_b = read_e(de_rta_q, de_rtv_q);
    unique case (de_alu_q)
      ALU_ADDU: em_res_d = e_a + e_b;
      ALU_SUBU: em_res_d = e_a - e_b;
      ALU_ORI:  em_res_d = e_a | {16'd0, de_imm_q};
      ALU_LUI:  em_res_d = {de_imm_q, 16'd0};
      ALU_MEM:  em_res_d = e_a + {{16{de_imm_q[15]}}, de_imm_q};
      ALU_LINK: em_res_d = de_pc_q + 32'd8;
      default:  em_res_d = 32'd0;
    endcase
    em_wr_d  = de_wr_q;
    em_lw_d  = de_lw_q;
    em_sw_d  = de_sw_q;
    em_sh_d  = de_sh_q;
    em_sb_d  = de_sb_q;
    em_dst_d = de_dst_q;
    em_pc_d  = de_pc_q;
    em_st_d  = e_b;
  end

  // M stage: lane steering replicates the source so only byteen selects the lane.
  always_comb begin
    m_data_byteen = 4'b0000;
    m_data_wdata  = em_st_q;
    if (em_sw_q) begin
      m_data_byteen = 4'b1111;
    end else if (em_sh_q) begin
      m_data_byteen = em_res_q[1] ? 4'b1100 : 4'b0011;
      m_data_wdata  = {2{em_st_q[15:0]}};
    end else if (em_sb_q) begin
      m_data_byteen = 4'b0001 << em_res_q[1:0];
      m_data_wdata  = {4{em_st_q[7:0]}};
    end
    mw_wr_d   = em_wr_q;
    mw_dst_d  = em_dst_q;
    mw_pc_d   = em_pc_q;
    mw_data_d = em_lw_q ? m_data_rdata : em_res_q;
  end

  assign i_inst_addr = pc_q;
  assign m_data_addr = em_res_q;
  assign m_inst_addr = em_pc_q;
  assign w_grf_we    = mw_wr_q;
  assign w_grf_addr  = mw_dst_q;
  assign w_grf_wdata = mw_data_q;
  assign w_inst_addr = mw_pc_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q       <= RESET_PC;
      fd_instr_q <= 32'd0;
      fd_pc_q    <= 32'd0;
      de_alu_q   <= ALU_NONE;
      de_wr_q    <= 1'b0;
      de_lw_q    <= 1'b0;
      de_sw_q    <= 1'b0;
      de_sh_q    <= 1'b0;
      de_sb_q    <= 1'b0;
      de_dst_q   <= 5'd0;
      de_rsa_q   <= 5'd0;
      de_rta_q   <= 5'd0;
      de_imm_q   <= 16'd0;
      de_pc_q    <= 32'd0;
      de_rsv_q   <= 32'd0;
      de_rtv_q   <= 32'd0;
      em_wr_q    <= 1'b0;
      em_lw_q    <= 1'b0;
      em_sw_q    <= 1'b0;
      em_sh_q    <= 1'b0;
      em_sb_q    <= 1'b0;
      em_dst_q   <= 5'd0;
      em_pc_q    <= 32'd0;
      em_res_q   <= 32'd0;
      em_st_q    <= 32'd0;
      mw_wr_q    <= 1'b0;
      mw_dst_q   <= 5'd0;
      mw_pc_q    <= 32'd0;
      mw_data_q  <= 32'd0;
    end else begin
      pc_q       <= pc_d;
      fd_instr_q <= fd_instr_d;
      fd_pc_q    <= fd_pc_d;
      de_alu_q   <= de_alu_d;
      de_wr_q    <= de_wr_d;
      de_lw_q    <= de_lw_d;
      de_sw_q    <= de_sw_d;
      de_sh_q    <= de_sh_d;
      de_sb_q    <= de_sb_d;
      de_dst_q   <= de_dst_d;
      de_rsa_q   <= de_rsa_d;
      de_rta_q   <= de_rta_d;
      de_imm_q   <= de_imm_d;
      de_pc_q    <= de_pc_d;
      de_rsv_q   <= de_rsv_d;
      de_rtv_q   <= de_rtv_d;
      em_wr_q    <= em_wr_d;
      em_lw_q    <= em_lw_d;
      em_sw_q    <= em_sw_d;
      em_sh_q    <= em_sh_d;
      em_sb_q    <= em_sb_d;
      em_dst_q   <= em_dst_d;
      em_pc_q    <= em_pc_d;
      em_res_q   <= em_res_d;
      em_st_q    <= em_st_d;
      mw_wr_q    <= mw_wr_d;
      mw_dst_q   <= mw_dst_d;
      mw_pc_q    <= mw_pc_d;
      mw_data_q  <= mw_data_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 32; gi++) begin : g_grf
      if (gi == 0) begin : g_zero
        always_ff @(posedge clk) grf_q[gi] <= 32'd0;
      end else begin : g_reg
        always_ff @(posedge clk) begin
          if (!reset)                                grf_q[gi] <= 32'd0;
          else if (mw_wr_q && mw_dst_q == 5'(gi))    grf_q[gi] <= mw_data_q;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_mips_pipeline_core.sv
// Directed bench for mips_pipeline_core: bench-side instruction/data memories,
// W-retire and M-store logs, and one task per feature with inline checks.
module tb_mips_pipeline_core;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] i_inst_addr, i_inst_rdata;
  logic [31:0] m_data_addr, m_data_rdata, m_data_wdata, m_inst_addr;
  logic [3:0]  m_data_byteen;
  logic        w_grf_we;
  logic [4:0]  w_grf_addr;
  logic [31:0] w_grf_wdata, w_inst_addr;

  always #5 clk = ~clk;

  mips_pipeline_core dut (
    .clk(clk), .reset(reset),
    .i_inst_addr(i_inst_addr), .i_inst_rdata(i_inst_rdata),
    .m_data_addr(m_data_addr), .m_data_rdata(m_data_rdata),
    .m_data_wdata(m_data_wdata), .m_data_byteen(m_data_byteen),
    .m_inst_addr(m_inst_addr),
    .w_grf_we(w_grf_we), .w_grf_addr(w_grf_addr), .w_grf_wdata(w_grf_wdata),
    .w_inst_addr(w_inst_addr)
  );

  logic [31:0] imem [64];
  logic [31:0] dmem [64];

  assign i_inst_rdata = (i_inst_addr >= 32'h3000 && i_inst_addr < 32'h3100) ? imem[i_inst_addr[7:2]] : 32'd0;
  assign m_data_rdata = dmem[m_data_addr[7:2]];

  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 64; i++) dmem[i] <= 32'd0;
    end else begin
      for (int b = 0; b < 4; b++)
        if (m_data_byteen[b]) dmem[m_data_addr[7:2]][8*b +: 8] <= m_data_wdata[8*b +: 8];
    end
  end

  // Cycle 0 is the first fetch after reset release.
  int          cyc, tr_n, st_n;
  logic [31:0] fa [64];
  logic [4:0]  tr_addr [64];
  logic [31:0] tr_data [64], tr_pc [64];
  int          tr_cyc [64];
  logic [31:0] st_addr [64], st_wdata [64], st_pc [64];
  logic [3:0]  st_be [64];

  always @(negedge clk) begin
    if (!reset) begin
      cyc = -1; tr_n = 0; st_n = 0;
    end else begin
      cyc++;
      if (cyc < 64) fa[cyc] = i_inst_addr;
      if (w_grf_we && tr_n < 64) begin
        tr_addr[tr_n] = w_grf_addr; tr_data[tr_n] = w_grf_wdata;
        tr_pc[tr_n] = w_inst_addr; tr_cyc[tr_n] = cyc;
        $display("[TB] retire cyc=%0d pc=%h r%0d <= %h", cyc, w_inst_addr, w_grf_addr, w_grf_wdata);
        tr_n++;
      end
      if (m_data_byteen != 4'd0 && st_n < 64) begin
        st_addr[st_n] = m_data_addr; st_wdata[st_n] = m_data_wdata;
        st_pc[st_n] = m_inst_addr; st_be[st_n] = m_data_byteen;
        $display("[TB] store  cyc=%0d pc=%h addr=%h be=%b data=%h", cyc, m_inst_addr, m_data_addr, m_data_byteen, m_data_wdata);
        st_n++;
      end
    end
  end

  int n_tests = 0, n_fail = 0;
  int idx, gotc;
  logic [31:0] got;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, rt, rd, input logic [5:0] funct);
    return {6'd0, rs, rt, rd, 5'd0, funct};
  endfunction
  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs, rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic int find_w(input logic [31:0] pc);
    for (int i = 0; i < tr_n; i++) if (tr_pc[i] == pc) return i;
    return -1;
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'd0;
  endtask

  task automatic run_program(input int ncyc);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (ncyc) @(posedge clk);
    @(negedge clk); #1;
  endtask

  task automatic test_reset();
    clear_imem();
    for (int i = 0; i < 16; i += 2) begin
      imem[i]   = enc_i(6'h0d, 5'd0, 5'd1, 16'h0001);
      imem[i+1] = enc_i(6'h2b, 5'd0, 5'd1, 16'h0000);
    end
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++; if (i_inst_addr !== 32'h3000) begin n_fail++; $display("FAIL reset_pc got=%h exp=%h", i_inst_addr, 32'h3000); end
    n_tests++; if (w_grf_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got=%b exp=0", w_grf_we); end
    n_tests++; if (m_data_byteen !== 4'd0) begin n_fail++; $display("FAIL reset_byteen got=%b exp=0000", m_data_byteen); end
    n_tests++; if (w_inst_addr !== 32'd0) begin n_fail++; $display("FAIL reset_w_pc got=%h exp=0", w_inst_addr); end
    // Mid-run reset with stores in flight.
    run_program(6);
    reset = 1'b0;
    @(posedge clk); @(negedge clk);
    n_tests++; if (i_inst_addr !== 32'h3000) begin n_fail++; $display("FAIL midreset_pc got=%h exp=%h", i_inst_addr, 32'h3000); end
    n_tests++; if (m_data_byteen !== 4'd0) begin n_fail++; $display("FAIL midreset_byteen got=%b exp=0000", m_data_byteen); end
    n_tests++; if (w_grf_we !== 1'b0) begin n_fail++; $display("FAIL midreset_we got=%b exp=0", w_grf_we); end
    n_tests++; if (m_inst_addr !== 32'd0) begin n_fail++; $display("FAIL midreset_m_pc got=%h exp=0", m_inst_addr); end
  endtask

  task automatic test_ori();
    clear_imem();
    imem[0] = enc_i(6'h0d, 5'd0, 5'd1, 16'h1234);
    run_program(10);
    idx = find_w(32'h3000);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'h0000_1234) begin n_fail++; $display("FAIL ori_wdata got=%h exp=%h", got, 32'h1234); end
    got = (idx < 0) ? 32'hxxxxxxxx : {27'd0, tr_addr[idx]};
    n_tests++; if (got !== 32'd1) begin n_fail++; $display("FAIL ori_addr got=%0d exp=1", got); end
    gotc = (idx < 0) ? -1 : tr_cyc[idx];
    n_tests++; if (gotc != 4) begin n_fail++; $display("FAIL ori_latency got=%0d exp=4", gotc); end
  endtask

  task automatic test_forward();
    clear_imem();
    imem[0] = enc_i(6'h0f, 5'd0, 5'd2, 16'h8000);
    imem[1] = enc_i(6'h0d, 5'd2, 5'd2, 16'h0001);
    imem[2] = enc_r(5'd2, 5'd2, 5'd3, 6'h21);
    imem[3] = enc_i(6'h0d, 5'd0, 5'd0, 16'h0005);
    imem[4] = enc_r(5'd0, 5'd0, 5'd19, 6'h21);
    run_program(14);
    idx = find_w(32'h3004);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'h8000_0001) begin n_fail++; $display("FAIL fwd_ori got=%h exp=%h", got, 32'h80000001); end
    idx = find_w(32'h3008);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'h0000_0002) begin n_fail++; $display("FAIL fwd_addu got=%h exp=%h", got, 32'h2); end
    gotc = (idx < 0) ? -1 : tr_cyc[idx];
    n_tests++; if (gotc != 6) begin n_fail++; $display("FAIL fwd_nostall got=%0d exp=6", gotc); end
    idx = find_w(32'h300C);
    got = (idx < 0) ? 32'hxxxxxxxx : {27'd0, tr_addr[idx]};
    n_tests++; if (got !== 32'd0) begin n_fail++; $display("FAIL r0_write_we got=%h exp=0", got); end
    idx = find_w(32'h3010);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'd0) begin n_fail++; $display("FAIL r0_no_fwd got=%h exp=0", got); end
  endtask

  task automatic test_grf_reset();
    clear_imem();
    imem[0] = enc_r(5'd3, 5'd0, 5'd20, 6'h21);
    run_program(8);
    idx = find_w(32'h3000);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'd0) begin n_fail++; $display("FAIL grf_cleared got=%h exp=0", got); end
  endtask

  task automatic test_stores();
    clear_imem();
    imem[0] = enc_i(6'h0d, 5'd0, 5'd4, 16'h0055);
    imem[1] = enc_i(6'h28, 5'd0, 5'd4, 16'h0003);
    imem[2] = enc_i(6'h0d, 5'd0, 5'd9, 16'hBEEF);
    imem[3] = enc_i(6'h29, 5'd0, 5'd9, 16'h0002);
    imem[4] = enc_i(6'h29, 5'd0, 5'd9, 16'h0004);
    run_program(12);
    n_tests++; if (st_n != 3) begin n_fail++; $display("FAIL store_count got=%0d exp=3", st_n); end
    if (st_n >= 3) begin
      n_tests++; if (st_addr[0] !== 32'd3) begin n_fail++; $display("FAIL sb_addr got=%h exp=3", st_addr[0]); end
      n_tests++; if (st_be[0] !== 4'b1000) begin n_fail++; $display("FAIL sb_byteen got=%b exp=1000", st_be[0]); end
      got = st_wdata[0];
      n_tests++; if (got[31:24] !== 8'h55) begin n_fail++; $display("FAIL sb_lane got=%h exp=55", got[31:24]); end
      n_tests++; if (st_pc[0] !== 32'h3004) begin n_fail++; $display("FAIL sb_m_pc got=%h exp=3004", st_pc[0]); end
      got = st_wdata[1];
      n_tests++; if (st_be[1] !== 4'b1100 || got[31:16] !== 16'hBEEF) begin n_fail++; $display("FAIL sh_hi got=%b/%h exp=1100/beef", st_be[1], got[31:16]); end
      got = st_wdata[2];
      n_tests++; if (st_be[2] !== 4'b0011 || got[15:0] !== 16'hBEEF) begin n_fail++; $display("FAIL sh_lo got=%b/%h exp=0011/beef", st_be[2], got[15:0]); end
    end
    n_tests++; if (dmem[0] !== 32'hBEEF_0000) begin n_fail++; $display("FAIL dmem0 got=%h exp=beef0000", dmem[0]); end
    n_tests++; if (dmem[1] !== 32'h0000_BEEF) begin n_fail++; $display("FAIL dmem1 got=%h exp=0000beef", dmem[1]); end
  endtask

  task automatic test_load_use();
    clear_imem();
    imem[0] = enc_i(6'h0f, 5'd0, 5'd2, 16'h8000);
    imem[1] = enc_i(6'h0d, 5'd2, 5'd2, 16'h0001);
    imem[2] = enc_i(6'h2b, 5'd0, 5'd2, 16'h0000);
    imem[3] = enc_i(6'h23, 5'd0, 5'd5, 16'h0000);
    imem[4] = enc_r(5'd5, 5'd5, 5'd6, 6'h21);
    run_program(14);
    n_tests++; if (st_n < 1 || st_be[0] !== 4'b1111 || st_wdata[0] !== 32'h8000_0001) begin
      n_fail++; $display("FAIL sw_store got_n=%0d be=%b data=%h exp=1111/80000001", st_n, st_be[0], st_wdata[0]); end
    idx = find_w(32'h300C);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'h8000_0001) begin n_fail++; $display("FAIL lw_data got=%h exp=80000001", got); end
    gotc = (idx < 0) ? -1 : tr_cyc[idx];
    idx = find_w(32'h3010);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'h0000_0002) begin n_fail++; $display("FAIL loaduse_addu got=%h exp=2", got); end
    gotc = (idx < 0) ? -1 : tr_cyc[idx] - gotc;
    n_tests++; if (gotc != 2) begin n_fail++; $display("FAIL loaduse_bubble gap got=%0d exp=2", gotc); end
  endtask

  task automatic test_beq();
    clear_imem();
    imem[0] = enc_i(6'h0d, 5'd0, 5'd7, 16'h0005);
    imem[1] = enc_i(6'h04, 5'd7, 5'd7, 16'h0003);  // target 0x3014
    imem[2] = enc_i(6'h0d, 5'd0, 5'd8, 16'h0001);
    imem[3] = enc_i(6'h0d, 5'd0, 5'd10, 16'h0BAD);
    imem[4] = enc_i(6'h0d, 5'd0, 5'd11, 16'h0BAD);
    imem[5] = enc_i(6'h0d, 5'd0, 5'd12, 16'h0007);
    imem[6] = enc_i(6'h04, 5'd7, 5'd0, 16'h0008);  // not taken
    imem[7] = enc_i(6'h0d, 5'd0, 5'd13, 16'h0002);
    imem[8] = enc_i(6'h0d, 5'd0, 5'd14, 16'h0003);
    run_program(20);
    idx = find_w(32'h3008);
    gotc = (idx < 0) ? -1 : tr_cyc[idx];
    n_tests++; if (gotc != 7) begin n_fail++; $display("FAIL beq_delay_slot cyc got=%0d exp=7", gotc); end
    idx = find_w(32'h300C);
    n_tests++; if (idx != -1) begin n_fail++; $display("FAIL beq_skip1 retired idx=%0d exp=none", idx); end
    idx = find_w(32'h3010);
    n_tests++; if (idx != -1) begin n_fail++; $display("FAIL beq_skip2 retired idx=%0d exp=none", idx); end
    n_tests++; if (fa[4] !== 32'h3014) begin n_fail++; $display("FAIL beq_target fetch got=%h exp=3014", fa[4]); end
    idx = find_w(32'h3014);
    gotc = (idx < 0) ? -1 : tr_cyc[idx];
    n_tests++; if (gotc != 8) begin n_fail++; $display("FAIL beq_target cyc got=%0d exp=8", gotc); end
    idx = find_w(32'h3020);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'd3) begin n_fail++; $display("FAIL beq_not_taken got=%h exp=3", got); end
  endtask

  task automatic test_jal_jr();
    clear_imem();
    imem[4]  = {6'h03, 26'h0000C10};                 // jal 0x3040
    imem[5]  = enc_i(6'h0d, 5'd0, 5'd15, 16'h0011);
    imem[6]  = enc_i(6'h0d, 5'd0, 5'd16, 16'h0022);
    imem[16] = enc_r(5'd31, 5'd0, 5'd0, 6'h08);      // jr $31
    imem[17] = enc_i(6'h0d, 5'd0, 5'd17, 16'h0033);
    imem[18] = enc_i(6'h0d, 5'd0, 5'd18, 16'h0BAD);
    run_program(20);
    idx = find_w(32'h3010);
    got = (idx < 0) ? 32'hxxxxxxxx : tr_data[idx];
    n_tests++; if (got !== 32'h3018) begin n_fail++; $display("FAIL jal_link got=%h exp=3018", got); end
    got = (idx < 0) ? 32'hxxxxxxxx : {27'd0, tr_addr[idx]};
    n_tests++; if (got !== 32'd31) begin n_fail++; $display("FAIL jal_dst got=%0d exp=31", got); end
    idx = find_w(32'h3014);
    n_tests++; if (idx < 0) begin n_fail++; $display("FAIL jal_delay_slot got=missing exp=retired"); end
    n_tests++; if (fa[6] !== 32'h3040) begin n_fail++; $display("FAIL jal_target fetch got=%h exp=3040", fa[6]); end
    n_tests++; if (fa[8] !== 32'h3018) begin n_fail++; $display("FAIL jr_return fetch got=%h exp=3018", fa[8]); end
    idx = find_w(32'h3048);
    n_tests++; if (idx != -1) begin n_fail++; $display("FAIL jr_skip retired idx=%0d exp=none", idx); end
    gotc = find_w(32'h3044);
    idx = find_w(32'h3018);
    n_tests++; if (gotc < 0 || idx < 0 || gotc > idx) begin n_fail++; $display("FAIL jr_order got=%0d,%0d exp=delay before return", gotc, idx); end
    gotc = (idx < 0) ? -1 : tr_cyc[idx];
    n_tests++; if (gotc != 12) begin n_fail++; $display("FAIL jr_return cyc got=%0d exp=12", gotc); end
  endtask

  initial begin
    test_reset();
    test_ori();
    test_forward();
    test_grf_reset();
    test_stores();
    test_load_use();
    test_beq();
    test_jal_jr();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
